// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream into and out of the FFT bit-reversal reorder buffer.
// The master drives samples in; the slave returns them in natural bin order.
interface fft_bitrev_reorder_if #(
    parameter int WIDTH = 24,
    parameter int N     = 1024
);
    localparam int LOG2N = $clog2(N);

    logic                    valid_i;
    logic                    sync_i;
    logic signed [WIDTH-1:0] x_re_i;
    logic signed [WIDTH-1:0] x_im_i;
    logic                    valid_o;
    logic                    sync_o;
    logic                    last_o;
    logic [LOG2N-1:0]        idx_o;
    logic signed [WIDTH-1:0] z_re_o;
    logic signed [WIDTH-1:0] z_im_o;
    logic                    err_o;

    modport master (
        output valid_i, sync_i, x_re_i, x_im_i,
        input  valid_o, sync_o, last_o, idx_o,
        input  z_re_o, z_im_o, err_o
    );

    modport slave (
        input  valid_i, sync_i, x_re_i, x_im_i,
        output valid_o, sync_o, last_o, idx_o,
        output z_re_o, z_im_o, err_o
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames written at bit-reversed addresses,
// drained in ascending bin order as one contiguous N-cycle burst.
module fft_bitrev_reorder #(
    parameter  int WIDTH = 24,
    parameter  int N     = 1024,
    localparam int LOG2N = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  srst_n,
    fft_bitrev_reorder_if.slave   bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    logic                    aligned_q, aligned_d;
    logic [LOG2N-1:0]        wr_cnt_q, wr_cnt_d;
    logic                    wr_bank_q, wr_bank_d;
    logic [1:0]              full_q, full_d;
    logic [0:0]              state_q, state_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]        rd_cnt_q, rd_cnt_d;
    logic                    err_q;
    logic                    vld_q, sync_q, last_q;
    logic [LOG2N-1:0]        idx_q;
    logic signed [WIDTH-1:0] re_q, im_q;

    logic [2*WIDTH-1:0]      mem_q [2*N];

    logic                    wr_en, wr_last, rd_issue, rd_done;
    logic [LOG2N-1:0]        wr_pos;

    // A sync always lands at bin 0, even when it cuts a frame short.
    assign wr_en    = bus.valid_i & (bus.sync_i | aligned_q);
    assign wr_pos   = bus.sync_i ? '0 : wr_cnt_q;
    assign wr_last  = wr_en & (wr_pos == '1);
    assign rd_issue = (state_q == S_READ);
    assign rd_done  = rd_issue & (rd_cnt_q == '1);

    always_comb begin
        aligned_d = aligned_q | (bus.valid_i & bus.sync_i);
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (wr_en) begin
            if (wr_last) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d  = wr_pos + LOG2N'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (|full_q) begin
                    state_d   = S_READ;
                    rd_bank_d = ~full_q[0];
                    rd_cnt_d  = '0;
                end else if (wr_last) begin
                    state_d   = S_READ;
                    rd_bank_d = wr_bank_q;
                    rd_cnt_d  = '0;
                end
            end
            S_READ: begin
                if (rd_done) begin
                    // Chain straight into the partner bank when it is ready.
                    if (full_q[~rd_bank_q] |
                        (wr_last & (wr_bank_q != rd_bank_q))) begin
                        rd_bank_d = ~rd_bank_q;
                        rd_cnt_d  = '0;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + LOG2N'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[{wr_bank_q, bitrev(wr_pos)}] <= {bus.x_re_i, bus.x_im_i};
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            aligned_q <= 1'b0;
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            state_q   <= S_IDLE;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            sync_q    <= 1'b0;
            last_q    <= 1'b0;
            idx_q     <= '0;
            re_q      <= '0;
            im_q      <= '0;
        end else begin
            aligned_q <= aligned_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            err_q     <= err_q |
                         (bus.valid_i & bus.sync_i & (wr_cnt_q != '0));
            vld_q     <= rd_issue;
            sync_q    <= rd_issue & (rd_cnt_q == '0);
            last_q    <= rd_done;
            if (rd_issue) begin
                idx_q        <= rd_cnt_q;
                {re_q, im_q} <= mem_q[{rd_bank_q, rd_cnt_q}];
            end
        end
    end

    assign bus.valid_o = vld_q;
    assign bus.sync_o  = sync_q;
    assign bus.last_o  = last_q;
    assign bus.idx_o   = idx_q;
    assign bus.z_re_o  = re_q;
    assign bus.z_im_o  = im_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with N=8: ordering, latency,
// back-to-back and gapped frames, alignment, restart error and reset.
module tb_fft_bitrev_reorder;
    localparam int W = 24;
    localparam int N = 8;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    int   cyc_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        int re;
        int im;
        int idx;
        bit sy;
        bit la;
        int cy;
    } out_t;
    out_t q[$];

    fft_bitrev_reorder_if #(.WIDTH(W), .N(N)) bus ();

    fft_bitrev_reorder #(.WIDTH(W), .N(N)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1)
            q.push_back('{int'(bus.z_re_o), int'(bus.z_im_o),
                          int'(bus.idx_o), bus.sync_o, bus.last_o, cyc_n});
    end

    function automatic int brev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit v, input bit s, input int re, input int im);
        bus.valid_i = v;
        bus.sync_i  = s;
        bus.x_re_i  = W'(re);
        bus.x_im_i  = W'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0);
    endtask

    task automatic send_frame(input int base, input bit gap);
        for (int k = 0; k < N; k++) begin
            cyc(1'b1, k == 0, base + brev3(k), -(base + brev3(k)));
            if (gap) idle(1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " valid_o"}, 64'(bus.valid_o), 64'd0);
        chk({tag, " sync_o"},  64'(bus.sync_o),  64'd0);
        chk({tag, " last_o"},  64'(bus.last_o),  64'd0);
        chk({tag, " idx_o"},   64'(bus.idx_o),   64'd0);
        chk({tag, " z_re_o"},  64'(bus.z_re_o),  64'd0);
        chk({tag, " z_im_o"},  64'(bus.z_im_o),  64'd0);
        chk({tag, " err_o"},   64'(bus.err_o),   64'd0);
    endtask

    // Expected: n outputs, bin j%N of each frame equal to base+f*step+j%N.
    task automatic chk_burst(input string tag, input int base,
                             input int step, input int c0, input int n);
        chk({tag, " count"}, 64'(q.size()), 64'(n));
        for (int j = 0; j < n; j++) begin
            if (j < q.size()) begin
                int b = j % N;
                int v = base + (j / N) * step + b;
                chk({tag, " re"},   64'(q[j].re),  64'(v));
                chk({tag, " im"},   64'(q[j].im),  64'(-v));
                chk({tag, " idx"},  64'(q[j].idx), 64'(b));
                chk({tag, " sync"}, 64'(q[j].sy),  64'(b == 0));
                chk({tag, " last"}, 64'(q[j].la),  64'(b == N - 1));
                chk({tag, " cyc"},  64'(q[j].cy),  64'(c0 + j));
            end
        end
        q.delete();
    endtask

    initial begin
        int s;
        bus.valid_i = 1'b0;
        bus.sync_i  = 1'b0;
        bus.x_re_i  = '0;
        bus.x_im_i  = '0;
        srst_n = 1'b0;
        idle(3);
        chk_reset_outputs("reset");
        srst_n = 1'b1;
        idle(2);
        chk_reset_outputs("post-reset idle");
        q.delete();

        // single contiguous frame: bin 0 at cycle 9 relative to sync
        s = cyc_n;
        send_frame(0, 1'b0);
        idle(12);
        chk_burst("single", 0, 0, s + 9, N);
        chk("single err_o", 64'(bus.err_o), 64'd0);

        // three back-to-back frames: 24 gapless outputs
        s = cyc_n;
        send_frame(100, 1'b0);
        send_frame(200, 1'b0);
        send_frame(300, 1'b0);
        idle(12);
        chk_burst("b2b", 100, 100, s + 9, 3 * N);

        // valid_i every other cycle: one burst after the 8th write
        s = cyc_n;
        send_frame(40, 1'b1);
        idle(12);
        chk_burst("gapped", 40, 0, s + 16, N);

        // fresh reset, unaligned samples are dropped before the sync frame
        srst_n = 1'b0;
        idle(1);
        srst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 777, -777);
        idle(12);
        chk("presync none", 64'(q.size()), 64'd0);
        s = cyc_n;
        send_frame(500, 1'b0);
        idle(12);
        chk_burst("presync", 500, 0, s + 9, N);

        // sync at position 5 restarts the frame and flags err_o
        for (int k = 0; k < 5; k++)
            cyc(1'b1, k == 0, 900 + brev3(k), -(900 + brev3(k)));
        chk("err before restart", 64'(bus.err_o), 64'd0);
        s = cyc_n;
        cyc(1'b1, 1'b1, 600, -600);
        chk("err after restart", 64'(bus.err_o), 64'd1);
        for (int k = 1; k < N; k++)
            cyc(1'b1, 1'b0, 600 + brev3(k), -(600 + brev3(k)));
        idle(12);
        chk_burst("restart", 600, 0, s + 9, N);
        chk("err sticky", 64'(bus.err_o), 64'd1);

        // reset in the middle of an output burst
        s = cyc_n;
        send_frame(700, 1'b0);
        idle(3);
        chk("burst running", 64'(bus.valid_o), 64'd1);
        srst_n = 1'b0;
        idle(1);
        srst_n = 1'b1;
        chk_reset_outputs("midburst reset");
        q.delete();
        idle(20);
        chk("after reset silent", 64'(q.size()), 64'd0);
        s = cyc_n;
        send_frame(800, 1'b0);
        idle(12);
        chk_burst("after reset", 800, 0, s + 9, N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
